// File: rtl/pwm_capture.sv
// pwm_capture: recovers a PWM DAC code by counting high cycles per window.
// Ports: clk, rst_n (async low), pwm_in (async) -> code, code_valid, locked, realign.
module pwm_capture #(
   parameter int CYCLES_PER_WINDOW = 1024,
   parameter int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW),
   parameter int SYNC_STAGES       = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pwm_in,
   output logic [CODE_WIDTH-1:0] code,
   output logic                  code_valid,
   output logic                  locked,
   output logic                  realign
);

   localparam int CW = CODE_WIDTH;
   localparam logic [CW-1:0] LAST    = CW'(CYCLES_PER_WINDOW - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW:0]   H_ONE   = (CW+1)'(1);

   typedef enum logic {
      HUNT,
      MEASURE
   } state_t;

   state_t               state, state_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic                 pwm_s, pwm_s_d, rise;
   logic [CW-1:0]        cnt, cnt_nx;
   logic [CW:0]          h, h_nx, h_sum, h_m1;
   logic [CW-1:0]        code_nx;
   logic                 valid_nx, locked_nx, realign_nx;

   assign pwm_s = sync[SYNC_STAGES-1];
   assign rise  = pwm_s & ~pwm_s_d;

   // h holds the high count of indices 0..cnt-1; h_sum adds this cycle
   assign h_sum = h + {{CW{1'b0}}, pwm_s};
   assign h_m1  = h_sum - H_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= '0;
         pwm_s_d <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], pwm_in};
         pwm_s_d <= pwm_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         cnt        <= '0;
         h          <= '0;
         code       <= '0;
         code_valid <= 1'b0;
         locked     <= 1'b0;
         realign    <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         h          <= h_nx;
         code       <= code_nx;
         code_valid <= valid_nx;
         locked     <= locked_nx;
         realign    <= realign_nx;
      end
   end

   // cnt is the HUNT timeout t or the MEASURE window index i
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt + CNT_ONE;
      h_nx       = h;
      code_nx    = code;
      valid_nx   = 1'b0;
      locked_nx  = locked;
      realign_nx = 1'b0;
      unique case (state)
         HUNT: begin
            if (rise) begin
               // this cycle is index 0, so the next one is index 1
               state_nx  = MEASURE;
               cnt_nx    = CNT_ONE;
               h_nx      = H_ONE;
               locked_nx = 1'b1;
            end else if (cnt == LAST) begin
               cnt_nx   = '0;
               code_nx  = pwm_s ? LAST : '0;
               valid_nx = 1'b1;
            end
         end
         MEASURE: begin
            if (rise && cnt != '0) begin
               // off-phase edge: drop the window, edge cycle is new index 0
               cnt_nx     = CNT_ONE;
               h_nx       = H_ONE;
               realign_nx = 1'b1;
            end else if (cnt == LAST) begin
               cnt_nx   = '0;
               h_nx     = '0;
               code_nx  = (h_sum == '0) ? '0 : h_m1[CW-1:0];
               valid_nx = 1'b1;
            end else begin
               h_nx = h_sum;
            end
         end
         default: begin
            state_nx = HUNT;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed vectors for pwm_capture with N=16.
// Strobe cycles and codes are logged on negedge and compared to hand values.
module tb_pwm_capture;

   logic       clk;
   logic       rst_n;
   logic       pwm_in;
   logic [3:0] code;
   logic       code_valid;
   logic       locked;
   logic       realign;

   int n_chk;
   int n_fail;
   int cyc;
   int lock_cyc;
   int r;
   int vcyc[$];
   int vcode[$];
   int rcyc[$];
   int exp_off[$];
   int exp_code[$];

   pwm_capture #(
      .CYCLES_PER_WINDOW(16),
      .CODE_WIDTH(4),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pwm_in(pwm_in),
      .code(code),
      .code_valid(code_valid),
      .locked(locked),
      .realign(realign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (code_valid) begin
            vcyc.push_back(cyc);
            vcode.push_back(int'(code));
         end
         if (realign) rcyc.push_back(cyc);
         if (code_valid && realign) check("valid_and_realign", 1, 0);
         if (locked && lock_cyc < 0) lock_cyc = cyc;
      end
   end

   task automatic clear_log();
      vcyc.delete();
      vcode.delete();
      rcyc.delete();
      lock_cyc = -1;
   endtask

   task automatic put(input logic v);
      pwm_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic put_dac(input int hi, input int reps);
      for (int k = 0; k < reps; k++)
         for (int j = 0; j < 16; j++) put(j < hi);
   endtask

   task automatic put_const(input logic v, input int n);
      for (int k = 0; k < n; k++) put(v);
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      r = cyc;
      clear_log();
      check("rst_code", 32'(code), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_valid", 32'(code_valid), 0);
      check("rst_realign", 32'(realign), 0);
   endtask

   task automatic verify(input string tag, input int base);
      check({tag, "_nvalid"}, vcyc.size(), exp_off.size());
      for (int i = 0; i < vcyc.size() && i < exp_off.size(); i++) begin
         check($sformatf("%s_cyc%0d", tag, i), vcyc[i] - base, exp_off[i]);
         check($sformatf("%s_code%0d", tag, i), vcode[i], exp_code[i]);
      end
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      lock_cyc = -1;
      rst_n    = 1'b0;
      pwm_in   = 1'b0;

      // 1: code 5 stream
      do_reset();
      put_dac(6, 5);
      put_const(1'b0, 4);
      exp_off  = {18, 34, 50, 66, 82};
      exp_code = {5, 5, 5, 5, 5};
      verify("t1", r);
      check("t1_lock_cyc", lock_cyc - r, 3);
      check("t1_realign", rcyc.size(), 0);

      // 2: constant low, HUNT timeouts
      do_reset();
      put_const(1'b0, 40);
      exp_off  = {16, 32};
      exp_code = {0, 0};
      verify("t2", r);
      check("t2_locked", 32'(locked), 0);

      // 3: constant high
      do_reset();
      put_const(1'b1, 52);
      exp_off  = {18, 34, 50};
      exp_code = {15, 15, 15};
      verify("t3", r);
      check("t3_lock_cyc", lock_cyc - r, 3);
      check("t3_realign", rcyc.size(), 0);

      // 4: codes 1, 0, 15, then all-low window
      do_reset();
      put_dac(2, 1);
      put_dac(0, 1);
      put_dac(16, 1);
      put_const(1'b0, 20);
      exp_off  = {18, 34, 50, 66};
      exp_code = {1, 0, 15, 0};
      verify("t4", r);
      check("t4_realign", rcyc.size(), 0);

      // 5: phase jump of 3 cycles
      do_reset();
      put_dac(6, 2);
      put_const(1'b0, 3);
      put_dac(6, 2);
      put_const(1'b0, 5);
      exp_off  = {18, 34, 53, 69};
      exp_code = {5, 5, 5, 5};
      verify("t5", r);
      check("t5_nrealign", rcyc.size(), 1);
      if (rcyc.size() > 0) check("t5_realign_cyc", rcyc[0] - r, 38);
      check("t5_locked", 32'(locked), 1);

      // 6: reset mid-window
      do_reset();
      for (int j = 0; j < 24; j++) put((j % 16) < 6);
      check("t6_pre_nvalid", vcyc.size(), 1);
      check("t6_pre_locked", 32'(locked), 1);
      rst_n = 1'b0;
      #1;
      check("t6_async_code", 32'(code), 0);
      check("t6_async_locked", 32'(locked), 0);
      check("t6_async_valid", 32'(code_valid), 0);
      check("t6_async_realign", 32'(realign), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      r = cyc;
      clear_log();
      put_dac(6, 2);
      put_const(1'b0, 4);
      exp_off  = {18, 34};
      exp_code = {5, 5};
      verify("t6", r);
      check("t6_lock_cyc", lock_cyc - r, 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
